// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues pc to instruction memory, tags each returning word with
// its address and queues {pc, inst} pairs toward decode. Redirects squash queued and in-flight fetches.
module ifetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        redirect,
    output logic        halt_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);
    // state | meaning
    // IDLE  | no imem request outstanding
    // WAIT  | request outstanding, its response will be queued
    // DROP  | request outstanding, its response was squashed by a redirect
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    state_t        state_q, state_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];

    logic        grant;
    logic        push;
    logic        pop;
    logic [CW:0] fill;
    logic        room;

    // Room is judged without the pop so id_ready never reaches imem_req combinationally.
    assign fill      = {1'b0, count_q} + {{CW{1'b0}}, push};
    assign room      = fill < DEPTH_W;
    assign imem_req  = rst_n & ((state_q == IDLE) | imem_rvalid) & (redirect | room);
    assign imem_addr = pc;
    assign grant     = imem_req & imem_gnt;
    assign halt_pc   = ~grant;

    assign push     = imem_rvalid & (state_q == WAIT) & ~redirect;
    assign id_valid = (count_q != '0) & ~redirect;
    assign pop      = id_valid & id_ready;
    assign id_inst  = q_inst[rd_ptr_q];
    assign id_pc    = q_pc[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid)   state_d = grant ? WAIT : IDLE;
                else if (redirect) state_d = DROP;
            end
            DROP: begin
                if (imem_rvalid) state_d = grant ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_pc_d = grant ? pc : req_pc_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Queue storage carries no reset; entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr_q]   <= req_pc_q;
            q_inst[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a PC generator and memory model drive the DUT; every accepted fetch
// is queued as an expected {pc, inst} pair and a monitor compares each decode handoff.
module tb_ifetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        redirect = 1'b0;
    logic        halt_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    ifetch_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .redirect(redirect), .halt_pc(halt_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
        .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
    );

    int tests = 0;
    int fails = 0;
    int delivered = 0;
    logic [63:0] exp_q[$];

    // Environment knobs, written only by the main sequence.
    int          gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0;
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int          slow_lat = 1;
    logic [31:0] redir_target = 32'h0, load_val = 32'h0;
    int          redir_seq = 0, load_seq = 0, stray_seq = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endfunction

    // PC generator, memory responder and scoreboard producer.
    initial begin : driver
        int          redir_ack = 0, load_ack = 0, stray_ack = 0;
        logic [31:0] pc_next = 32'h0;
        bit          mem_busy = 0;
        int          mem_cnt = 0;
        logic [31:0] mem_addr = 32'h0;
        forever begin
            @(posedge clk); #1;
            redirect    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (load_ack != load_seq) begin
                pc = load_val;
                load_ack = load_seq;
            end else if (redir_ack != redir_seq) begin
                pc = redir_target;
                redirect = 1'b1;
                redir_ack = redir_seq;
            end else if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
                pc = 32'($urandom_range(1023)) << 2;
                redirect = 1'b1;
            end else begin
                pc = pc_next;
            end
            imem_gnt = ($urandom_range(99) < gnt_pct);
            id_ready = ($urandom_range(99) < ready_pct);
            if (stray_ack != stray_seq) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
                stray_ack   = stray_seq;
            end else if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_addr ^ XMASK;
                    mem_busy    = 0;
                end
            end

            @(negedge clk);
            if (imem_req && imem_gnt) begin
                mem_busy = 1;
                mem_addr = imem_addr;
                mem_cnt  = (imem_addr == slow_addr) ? slow_lat : $urandom_range(lat_max, lat_min);
            end
            pc_next = halt_pc ? pc : pc + 32'd4;
            if (!rst_n || redirect) exp_q.delete();
            if (!halt_pc) begin
                chk("imem_addr_vs_pc", imem_addr, pc);
                exp_q.push_back({pc, pc ^ XMASK});
            end
            if (dut.push) begin
                tests++;
                if (dut.count_q == DEPTH) begin
                    fails++;
                    $display("FAIL push_when_full: count %0d, required below %0d", dut.count_q, DEPTH);
                end
            end
        end
    end

    // Consumer side: every decode handoff must match the oldest surviving fetch.
    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && id_valid && id_ready) begin
                tests++;
                if (redirect) begin
                    fails++;
                    $display("FAIL valid_on_redirect: got id_valid 1 pc %08h, required 0", id_pc);
                end else if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_delivery: got pc %08h, required none", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    delivered++;
                    if ({id_pc, id_inst} !== e) begin
                        fails++;
                        $display("FAIL delivery: got pc %08h inst %08h, required pc %08h inst %08h",
                                 id_pc, id_inst, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic do_reset(input logic [31:0] start);
        @(posedge clk); #3;
        rst_n = 1'b0;
        load_val = start;
        load_seq++;
        repeat (2) begin
            @(negedge clk);
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_halt_pc", 32'(halt_pc), 32'd1);
            chk("rst_id_valid", 32'(id_valid), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input logic [31:0] addr, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req && imem_gnt && imem_addr == addr) && n < 50);
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL %s: no grant of %08h within 50 cycles, required one", name, addr);
        end
    endtask

    initial begin : main
        int d0;
        // Reset and streaming.
        do_reset(32'h0);
        @(negedge clk);
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("c2_valid", 32'(id_valid), 32'd1);
        chk("c2_pc", id_pc, 32'h0);
        chk("c2_inst", id_inst, 32'hA5A5_0000);
        repeat (20) @(negedge clk);

        // Backpressure: queue fills with 0 and 4, then drains in order.
        ready_pct = 0;
        do_reset(32'h0);
        repeat (4) @(negedge clk);
        chk("bp_req", 32'(imem_req), 32'd0);
        chk("bp_halt", 32'(halt_pc), 32'd1);
        chk("bp_head_valid", 32'(id_valid), 32'd1);
        chk("bp_head_pc", id_pc, 32'h0);
        d0 = delivered;
        ready_pct = 100;
        repeat (12) @(negedge clk);
        chk("bp_drained_3", 32'(delivered - d0 >= 3), 32'd1);

        // Redirect while a slow response is outstanding.
        slow_addr = 32'h8;
        slow_lat  = 3;
        do_reset(32'h0);
        wait_grant(32'h8, "grant_addr8");
        redir_target = 32'h100;
        redir_seq++;
        @(negedge clk);
        chk("drop_hold_1", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("drop_hold_2", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("drop_issue_req", 32'(imem_req), 32'd1);
        chk("drop_issue_addr", imem_addr, 32'h100);
        @(negedge clk);
        @(negedge clk);
        chk("drop_target_valid", 32'(id_valid), 32'd1);
        chk("drop_target_pc", id_pc, 32'h100);
        slow_addr = 32'hFFFF_FFFF;
        repeat (5) @(negedge clk);

        // Redirect in the same cycle as a response.
        ready_pct = 0;
        do_reset(32'h0);
        wait_grant(32'h4, "grant_addr4");
        redir_target = 32'h200;
        redir_seq++;
        @(negedge clk);
        chk("rv_redir_valid", 32'(id_valid), 32'd0);
        chk("rv_redir_req", 32'(imem_req), 32'd1);
        chk("rv_redir_addr", imem_addr, 32'h200);
        chk("rv_redir_halt", 32'(halt_pc), 32'd0);
        @(negedge clk);
        chk("rv_queue_empty", 32'(id_valid), 32'd0);
        @(negedge clk);
        chk("rv_target_valid", 32'(id_valid), 32'd1);
        chk("rv_target_pc", id_pc, 32'h200);
        chk("rv_target_inst", id_inst, 32'h200 ^ XMASK);
        ready_pct = 100;
        repeat (6) @(negedge clk);

        // Slow grant.
        gnt_pct = 0;
        do_reset(32'h40);
        repeat (4) begin
            @(negedge clk);
            chk("sg_halt", 32'(halt_pc), 32'd1);
            chk("sg_addr", imem_addr, 32'h40);
        end
        gnt_pct = 100;
        @(negedge clk);
        chk("sg_accept", 32'(halt_pc), 32'd0);
        gnt_pct = 0;
        @(negedge clk);
        chk("sg_halt_after", 32'(halt_pc), 32'd1);
        chk("sg_next_addr", imem_addr, 32'h44);
        repeat (4) @(negedge clk);

        // Reset mid-stream with a full queue, then a stray response.
        gnt_pct = 100;
        ready_pct = 0;
        do_reset(32'h0);
        repeat (5) @(negedge clk);
        chk("mr_full", 32'(id_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        gnt_pct = 0;
        #1;
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_halt", 32'(halt_pc), 32'd1);
        chk("mr_valid", 32'(id_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        stray_seq++;
        repeat (3) begin
            @(negedge clk);
            chk("mr_stray_ignored", 32'(id_valid), 32'd0);
        end

        // Randomized traffic with redirects and one mid-stream reset.
        for (int seg = 0; seg < 6; seg++) begin
            gnt_pct   = $urandom_range(100, 30);
            ready_pct = $urandom_range(100, 20);
            lat_max   = $urandom_range(4, 1);
            redir_pct = $urandom_range(8, 0);
            if (seg == 0) do_reset(32'h0);
            if (seg == 3) do_reset(32'h1000);
            repeat (400) @(negedge clk);
        end
        redir_pct = 0;
        gnt_pct   = 0;
        ready_pct = 100;
        repeat (20) @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("random_delivered", 32'(delivered >= 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
